// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding and parity modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full flag and occupancy count.
// Latency: a push is visible at the head (empty=0) on the cycle after the write.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Occupancy after this cycle's accepted push/pop; simultaneous ones cancel.
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally at the power-of-two depth; full is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
    end
  end

  // Storage array needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter: FIFO of words serialised LSB-first with optional parity.
// Latency: write at N pops at N+1, start bit on the first baud strobe at or after N+2.
// Backpressure: writes while full are dropped and flagged by a one-cycle overflow pulse.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  input  logic                 clken,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 full,
  output logic                 overflow
);

  localparam int CW = $clog2(FIFO_DEPTH);

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [3:0]           bitpos, bitpos_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic                 par_q, par_nxt;
  logic                 tx_q, tx_nxt;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_dat;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW:0]          fifo_count;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (pop),
    .wdata (din),
    .rdata (fifo_dat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx      = tx_q;
  assign full    = fifo_full;
  assign tx_busy = (state != ST_IDLE) || (fifo_count != '0);

  // Serialiser next-state: every state but IDLE advances only on the baud strobe.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bitpos_nxt   = bitpos;
    stop_cnt_nxt = stop_cnt;
    par_nxt      = par_q;
    tx_nxt       = tx_q;
    pop          = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop          = 1'b1;
          shreg_nxt    = fifo_dat;
          par_nxt      = (PARITY == PAR_ODD) ? ~^fifo_dat : ^fifo_dat;
          bitpos_nxt   = '0;
          stop_cnt_nxt = 1'b0;
          state_nxt    = ST_START;
        end
      end
      ST_START: begin
        if (clken) begin
          tx_nxt    = 1'b0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (clken) begin
          // Shift out LSB-first; parity was captured whole at pop time.
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
          if (bitpos == 4'(DATA_BITS - 1)) begin
            state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bitpos_nxt = bitpos + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (clken) begin
          tx_nxt    = par_q;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clken) begin
          tx_nxt = 1'b1;
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_nxt = ST_IDLE;
          end else begin
            stop_cnt_nxt = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Serialiser state register; reset forces the line idle at once.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bitpos   <= '0;
      stop_cnt <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bitpos   <= bitpos_nxt;
      stop_cnt <= stop_cnt_nxt;
      par_q    <= par_nxt;
      tx_q     <= tx_nxt;
    end
  end

  // A write attempted against the registered full flag is a dropped word.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= wr_en && fifo_full;
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param across several parameter sets.
// Latency: frames are captured sample-per-cycle with a 4-cycle baud strobe.
// Backpressure: exercises full, dropped writes and simultaneous push/pop.
module tb_uart_tx_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic [4:0] wr = '0;
  logic       auto_en = 1'b0;
  logic       man_clken = 1'b0;
  logic [1:0] phase = '0;
  logic       clken;

  logic tx0, tx1, tx2, tx3, tx4;
  logic busy0, busy1, busy2, busy3, busy4;
  logic full0, full1, full2, full3, full4;
  logic ovf0, ovf1, ovf2, ovf3, ovf4;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  // Baud phase advances on the falling edge so clken is stable at rising edges.
  always @(negedge clk) phase <= phase + 2'd1;
  assign clken = (auto_en && phase == 2'd3) || man_clken;

  // u0: 8N1 depth 4; u1: 8E1; u2: 8O1; u3: 7E1; u4: 8N2.
  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk_50m(clk), .rst_n(rst_n), .din(din), .wr_en(wr[0]), .clken(clken),
    .tx(tx0), .tx_busy(busy0), .full(full0), .overflow(ovf0));
  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk_50m(clk), .rst_n(rst_n), .din(din), .wr_en(wr[1]), .clken(clken),
    .tx(tx1), .tx_busy(busy1), .full(full1), .overflow(ovf1));
  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk_50m(clk), .rst_n(rst_n), .din(din), .wr_en(wr[2]), .clken(clken),
    .tx(tx2), .tx_busy(busy2), .full(full2), .overflow(ovf2));
  uart_tx_fifo_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clk_50m(clk), .rst_n(rst_n), .din(din[6:0]), .wr_en(wr[3]), .clken(clken),
    .tx(tx3), .tx_busy(busy3), .full(full3), .overflow(ovf3));
  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u4 (
    .clk_50m(clk), .rst_n(rst_n), .din(din), .wr_en(wr[4]), .clken(clken),
    .tx(tx4), .tx_busy(busy4), .full(full4), .overflow(ovf4));

  function automatic logic get_tx(input int i);
    case (i)
      1: return tx1;
      2: return tx2;
      3: return tx3;
      4: return tx4;
      default: return tx0;
    endcase
  endfunction

  // Called at #1 after a rising edge; strobes wr_en for one cycle.
  task automatic do_write(input int inst, input logic [7:0] d);
    din = d;
    wr[inst] = 1'b1;
    @(posedge clk); #1;
    wr[inst] = 1'b0;
  endtask

  // Records one level per 4-cycle bit period, starting at the first low sample.
  task automatic capture(input int inst, input int nbits, input int timeout,
                         output logic [31:0] bits, output logic stable, output logic found);
    logic v;
    bits = '0;
    stable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < timeout && !found; i++) begin
      @(posedge clk); #1;
      if (get_tx(inst) == 1'b0) found = 1'b1;
    end
    if (found) begin
      for (int b = 0; b < nbits; b++) begin
        for (int k = 0; k < 4; k++) begin
          if (!(b == 0 && k == 0)) begin
            @(posedge clk); #1;
          end
          v = get_tx(inst);
          if (k == 0) bits[b] = v;
          else if (v !== bits[b]) stable = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx0, tx1, tx2, tx3, tx4} !== 5'b11111) begin
      failures++; $display("FAIL reset_tx: got %b expected 11111", {tx0, tx1, tx2, tx3, tx4});
    end
    checks++;
    if ({busy0, full0, ovf0, busy4, full4, ovf4} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 000000", {busy0, full0, ovf0, busy4, full4, ovf4});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tx0, busy0, full0, ovf0} !== 4'b1000) begin
      failures++; $display("FAIL post_reset: got %b expected 1000", {tx0, busy0, full0, ovf0});
    end
  endtask

  task automatic test_basic_frame;
    logic [31:0] bits;
    logic stable, found;
    auto_en = 1'b1;
    do_write(0, 8'hA5);
    checks++;
    if (busy0 !== 1'b1) begin
      failures++; $display("FAIL busy_rise: got %b expected 1", busy0);
    end
    capture(0, 10, 100, bits, stable, found);
    checks++;
    // start 0, A5 LSB-first 1,0,1,0,0,1,0,1, stop 1 (bit 0 on the right)
    if (!found || bits[9:0] !== 10'b1101001010) begin
      failures++; $display("FAIL frame_a5: got %b expected 1101001010 found=%b", bits[9:0], found);
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++; $display("FAIL hold_a5: got %b expected 1", stable);
    end
    checks++;
    if (busy0 !== 1'b0) begin
      failures++; $display("FAIL busy_fall: got %b expected 0", busy0);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_parity;
    logic [31:0] bits;
    logic stable, found;
    auto_en = 1'b1;
    do_write(1, 8'h07);
    capture(1, 11, 100, bits, stable, found);
    checks++;
    // even parity of three ones is 1
    if (!found || !stable || bits[10:0] !== 11'b11000001110) begin
      failures++; $display("FAIL even_07: got %b expected 11000001110 found=%b stable=%b", bits[10:0], found, stable);
    end
    do_write(2, 8'h07);
    capture(2, 11, 100, bits, stable, found);
    checks++;
    if (!found || !stable || bits[10:0] !== 11'b10000001110) begin
      failures++; $display("FAIL odd_07: got %b expected 10000001110 found=%b stable=%b", bits[10:0], found, stable);
    end
    do_write(3, 8'h7F);
    capture(3, 10, 100, bits, stable, found);
    checks++;
    // seven data ones, even parity 1
    if (!found || !stable || bits[9:0] !== 10'b1111111110) begin
      failures++; $display("FAIL even7_7f: got %b expected 1111111110 found=%b stable=%b", bits[9:0], found, stable);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] bits;
    logic stable, found;
    auto_en = 1'b1;
    do_write(4, 8'h00);
    do_write(4, 8'hFF);
    capture(4, 22, 100, bits, stable, found);
    checks++;
    // frame 00 + two stops, then frame FF + two stops, no idle gap
    if (!found || bits[21:0] !== 22'b1111111111011000000000) begin
      failures++; $display("FAIL two_stop_b2b: got %b expected 1111111111011000000000 found=%b", bits[21:0], found);
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++; $display("FAIL two_stop_hold: got %b expected 1", stable);
    end
    checks++;
    if (busy4 !== 1'b0) begin
      failures++; $display("FAIL two_stop_busy: got %b expected 0", busy4);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_fifo_full;
    logic [31:0] bits;
    logic stable, found;
    logic [9:0] exp_frames [5];
    exp_frames[0] = 10'b1001000100; // 22
    exp_frames[1] = 10'b1001100110; // 33
    exp_frames[2] = 10'b1010001000; // 44
    exp_frames[3] = 10'b1010101010; // 55
    exp_frames[4] = 10'b1011101110; // 77
    // 11 is popped and parks in START (no strobe), so no further pops occur.
    do_write(0, 8'h11);
    repeat (3) @(posedge clk);
    #1;
    do_write(0, 8'h22);
    do_write(0, 8'h33);
    do_write(0, 8'h44);
    checks++;
    if (full0 !== 1'b0) begin
      failures++; $display("FAIL full_at3: got %b expected 0", full0);
    end
    do_write(0, 8'h55);
    checks++;
    if (full0 !== 1'b1 || ovf0 !== 1'b0) begin
      failures++; $display("FAIL full_at4: got full=%b ovf=%b expected full=1 ovf=0", full0, ovf0);
    end
    do_write(0, 8'h66);
    checks++;
    if (ovf0 !== 1'b1) begin
      failures++; $display("FAIL ovf_pulse: got %b expected 1", ovf0);
    end
    @(posedge clk); #1;
    checks++;
    if (ovf0 !== 1'b0 || full0 !== 1'b1) begin
      failures++; $display("FAIL ovf_once: got ovf=%b full=%b expected ovf=0 full=1", ovf0, full0);
    end
    // Ten consecutive strobes finish frame 11; the FSM is then in IDLE for one cycle.
    man_clken = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    man_clken = 1'b0;
    do_write(0, 8'h99);
    checks++;
    if (full0 !== 1'b0 || ovf0 !== 1'b1) begin
      failures++; $display("FAIL push_pop_full: got full=%b ovf=%b expected full=0 ovf=1", full0, ovf0);
    end
    do_write(0, 8'h77);
    checks++;
    if (full0 !== 1'b1 || ovf0 !== 1'b0) begin
      failures++; $display("FAIL retry_write: got full=%b ovf=%b expected full=1 ovf=0", full0, ovf0);
    end
    auto_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      capture(0, 10, 100, bits, stable, found);
      checks++;
      if (!found || !stable || bits[9:0] !== exp_frames[f]) begin
        failures++; $display("FAIL fifo_order_%0d: got %b expected %b found=%b stable=%b", f, bits[9:0], exp_frames[f], found, stable);
      end
    end
    checks++;
    if (busy0 !== 1'b0 || full0 !== 1'b0) begin
      failures++; $display("FAIL fifo_drained: got busy=%b full=%b expected 0 0", busy0, full0);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] bits;
    logic stable, found;
    auto_en = 1'b1;
    do_write(0, 8'hA1);
    do_write(0, 8'hB2);
    do_write(0, 8'hC3);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (tx0 == 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL mid_start: got no start bit expected one within 100 cycles");
    end
    // Middle of bit period 4 = data bit 3 of A1, which is 0.
    repeat (17) @(posedge clk);
    #1;
    checks++;
    if (tx0 !== 1'b0) begin
      failures++; $display("FAIL mid_bit3: got %b expected 0", tx0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || full0 !== 1'b0) begin
      failures++; $display("FAIL mid_reset: got tx=%b busy=%b full=%b expected 1 0 0", tx0, busy0, full0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    capture(0, 1, 60, bits, stable, found);
    checks++;
    if (found !== 1'b0 || busy0 !== 1'b0) begin
      failures++; $display("FAIL queue_discard: got start=%b busy=%b expected 0 0", found, busy0);
    end
    do_write(0, 8'h3C);
    capture(0, 10, 100, bits, stable, found);
    checks++;
    if (!found || !stable || bits[9:0] !== 10'b1001111000) begin
      failures++; $display("FAIL after_reset_3c: got %b expected 1001111000 found=%b stable=%b", bits[9:0], found, stable);
    end
    auto_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
